// File: rtl/bnn_pkg.sv
// Shared constants and types for the binary neural network datapath.
package bnn_pkg;

  localparam int BNN_FC_IN_W   = 400;
  localparam int BNN_N_CLASSES = 10;
  localparam int BNN_PIX_W     = 16;
  localparam int BNN_N_PIX     = 25;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_e;

  function automatic int bnn_vec_width(input int word_w, input int n_words);
    return word_w * n_words;
  endfunction

endpackage

// File: rtl/bnn_pack_buf.sv
// One frame buffer: word-indexed write port, registered contents and a frame-complete flag.
module bnn_pack_buf
  import bnn_pkg::*;
#(
  parameter int WORD_W  = BNN_PIX_W,
  parameter int N_WORDS = BNN_N_PIX,
  parameter int IDX_W   = $clog2(BNN_N_PIX)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [WORD_W-1:0]           wr_data,
  input  logic                        set_complete,
  input  logic                        clr_complete,
  output logic [WORD_W*N_WORDS-1:0]   data,
  output logic [WORD_W*N_WORDS-1:0]   merged,
  output logic                        complete
);

  localparam int VEC_W = bnn_vec_width(WORD_W, N_WORDS);

  logic [VEC_W-1:0] data_r;
  logic             complete_r;

  // Slot storage and complete flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r     <= {VEC_W{1'b0}};
      complete_r <= 1'b0;
    end else begin
      if (wr_en) begin
        data_r[int'(wr_idx)*WORD_W +: WORD_W] <= wr_data;
      end
      if (set_complete) begin
        complete_r <= 1'b1;
      end else if (clr_complete) begin
        complete_r <= 1'b0;
      end
    end
  end

  // Contents as they will be after this cycle's write, so a finishing word can be forwarded.
  always_comb begin
    merged = data_r;
    if (wr_en) begin
      merged[int'(wr_idx)*WORD_W +: WORD_W] = wr_data;
    end else begin
      merged = data_r;
    end
  end

  assign data     = data_r;
  assign complete = complete_r;

endmodule

// File: rtl/bnn_flatten_pack.sv
// Packs N_WORDS binarized pixel words into one FC input vector with framing checks.
// Optional ping-pong buffering: define BNN_FLATTEN_PACK_DOUBLE_BUF_EN.
module bnn_flatten_pack
  import bnn_pkg::*;
#(
  parameter int WORD_W  = BNN_PIX_W,
  parameter int N_WORDS = BNN_N_PIX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic                      fc_ready,
  output logic                      out_valid,
  output logic [WORD_W*N_WORDS-1:0] out_vector,
  output logic                      frame_err
);

  localparam int VEC_W = bnn_vec_width(WORD_W, N_WORDS);
  localparam int CNT_W = $clog2(N_WORDS);
`ifdef BNN_FLATTEN_PACK_DOUBLE_BUF_EN
  localparam int N_BUF = 2;
`else
  localparam int N_BUF = 1;
`endif

  generate
    if (VEC_W != BNN_FC_IN_W) begin : g_width_check
      $error("bnn_flatten_pack: VEC_W must equal BNN_FC_IN_W");
    end
  endgenerate

  pack_state_e      state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             wr_sel_r, wr_sel_next_s;
  logic             rd_sel_r, rd_sel_next_s;
  logic             in_ready_r, out_valid_r, frame_err_r;
  logic [VEC_W-1:0] out_vector_r;

  logic             accept_s, last_slot_s, good_s, bad_s, send_s;
  logic             load_s;
  logic [VEC_W-1:0] load_vec_s;
  logic             rd_complete_s;
  logic [VEC_W-1:0] rd_data_s, wr_merged_s;

  logic [N_BUF-1:0] buf_wr_en_s, buf_set_s, buf_clr_s, buf_complete_s, complete_next_s;
  logic [VEC_W-1:0] buf_data_s   [N_BUF];
  logic [VEC_W-1:0] buf_merged_s [N_BUF];

  assign accept_s    = in_valid & in_ready_r;
  assign last_slot_s = (cnt_r == CNT_W'(N_WORDS - 1));
  assign good_s      = accept_s & in_last & last_slot_s;
  assign bad_s       = accept_s & (in_last ^ last_slot_s);
  assign send_s      = (state_r == FULL) & fc_ready;

  generate
    for (genvar i = 0; i < N_BUF; i++) begin : g_buf
      bnn_pack_buf #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS),
        .IDX_W   (CNT_W)
      ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (buf_wr_en_s[i]),
        .wr_idx       (cnt_r),
        .wr_data      (in_data),
        .set_complete (buf_set_s[i]),
        .clr_complete (buf_clr_s[i]),
        .data         (buf_data_s[i]),
        .merged       (buf_merged_s[i]),
        .complete     (buf_complete_s[i])
      );
    end
  endgenerate

  // Steer writes to the fill buffer and the complete-flag clear to the oldest pending buffer.
  always_comb begin
    buf_wr_en_s     = {N_BUF{1'b0}};
    buf_set_s       = {N_BUF{1'b0}};
    buf_clr_s       = {N_BUF{1'b0}};
    complete_next_s = {N_BUF{1'b0}};
    for (int i = 0; i < N_BUF; i++) begin
      if (1'(i) == wr_sel_r) begin
        buf_wr_en_s[i] = accept_s;
        buf_set_s[i]   = good_s;
      end else begin
        buf_wr_en_s[i] = 1'b0;
        buf_set_s[i]   = 1'b0;
      end
      if (1'(i) == rd_sel_r) begin
        buf_clr_s[i] = send_s;
      end else begin
        buf_clr_s[i] = 1'b0;
      end
      complete_next_s[i] = (buf_complete_s[i] | buf_set_s[i]) & ~buf_clr_s[i];
    end
  end

  // Read-side and write-side buffer views for the output loader.
  always_comb begin
    rd_complete_s = 1'b0;
    rd_data_s     = {VEC_W{1'b0}};
    wr_merged_s   = {VEC_W{1'b0}};
    for (int i = 0; i < N_BUF; i++) begin
      if (1'(i) == rd_sel_r) begin
        rd_complete_s = buf_complete_s[i];
        rd_data_s     = buf_data_s[i];
      end else begin
        rd_complete_s = rd_complete_s;
      end
      if (1'(i) == wr_sel_r) begin
        wr_merged_s = buf_merged_s[i];
      end else begin
        wr_merged_s = wr_merged_s;
      end
    end
  end

  // Word counter and buffer pointers.
  always_comb begin
    cnt_next_s    = cnt_r;
    wr_sel_next_s = wr_sel_r;
    rd_sel_next_s = rd_sel_r;
    if (accept_s) begin
      if (in_last || last_slot_s) begin
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
`ifdef BNN_FLATTEN_PACK_DOUBLE_BUF_EN
    wr_sel_next_s = good_s ? ~wr_sel_r : wr_sel_r;
    rd_sel_next_s = send_s ? ~rd_sel_r : rd_sel_r;
`else
    wr_sel_next_s = wr_sel_r;
    rd_sel_next_s = rd_sel_r;
`endif
  end

  // FSM next state: FULL means out_vector holds a frame not yet handed to the FC stage.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    load_vec_s   = rd_data_s;
    case (state_r)
      FILL: begin
        if (rd_complete_s) begin
          load_s       = 1'b1;
          load_vec_s   = rd_data_s;
          state_next_s = FULL;
        end else if (good_s && (wr_sel_r == rd_sel_r)) begin
          load_s       = 1'b1;
          load_vec_s   = wr_merged_s;
          state_next_s = FULL;
        end else begin
          state_next_s = FILL;
        end
      end
      FULL: begin
        if (fc_ready) begin
          state_next_s = FILL;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = FILL;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= FILL;
      cnt_r        <= {CNT_W{1'b0}};
      wr_sel_r     <= 1'b0;
      rd_sel_r     <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      frame_err_r  <= 1'b0;
      out_vector_r <= {VEC_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      wr_sel_r    <= wr_sel_next_s;
      rd_sel_r    <= rd_sel_next_s;
      in_ready_r  <= ~(&complete_next_s);
      out_valid_r <= send_s;
      frame_err_r <= bad_s;
      if (load_s) begin
        out_vector_r <= load_vec_s;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign frame_err  = frame_err_r;
  assign out_vector = out_vector_r;

endmodule

// File: tb/tb_bnn_flatten_pack.sv
// Directed self-checking bench for bnn_flatten_pack (single or ping-pong build).
module tb_bnn_flatten_pack;

`ifdef BNN_FLATTEN_PACK_DOUBLE_BUF_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         fc_ready;
  logic         out_valid;
  logic [399:0] out_vector;
  logic         frame_err;

  int checks;
  int failures;

  bnn_flatten_pack dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .fc_ready   (fc_ready),
    .out_valid  (out_valid),
    .out_vector (out_vector),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [399:0] build_vec(input logic [15:0] base);
    logic [399:0] v;
    v = '0;
    for (int k = 0; k < 25; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // Streams n words base, base+1, ...; in_last on index last_idx (-1: never).
  task automatic send_words(input logic [15:0] base, input int n, input int last_idx);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(k);
      in_last  = (k == last_idx);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    checks++; if (out_vector !== 400'd0) begin failures++; $display("FAIL reset_out_vector got=%h exp=0", out_vector); end
    do_reset();
  endtask

  task automatic test_basic_frame();
    logic [399:0] exp;
    exp = build_vec(16'h0001);
    fc_ready = 1'b1;
    send_words(16'h0001, 25, 24);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== DBL) begin failures++; $display("FAIL t1_full_in_ready got=%0b exp=%0b", in_ready, DBL); end
    checks++; if (out_vector[15:0] !== 16'h0001 || out_vector[399:384] !== 16'h0019) begin
      failures++; $display("FAIL t1_slots got_lo=%h got_hi=%h exp_lo=0001 exp_hi=0019", out_vector[15:0], out_vector[399:384]);
    end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t1_pulse got=%0b exp=1", out_valid); end
    checks++; if (out_vector !== exp) begin failures++; $display("FAIL t1_vector got=%h exp=%h", out_vector, exp); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_pulse_end got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL t1_ready_back got=%0b exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [399:0] exp;
    int pulses;
    exp = build_vec(16'hA000);
    fc_ready = 1'b0;
    send_words(16'hA000, 25, 24);
    for (int i = 0; i < 10; i++) begin
      checks++; if (in_ready !== DBL) begin failures++; $display("FAIL t2_hold_ready cyc=%0d got=%0b exp=%0b", i, in_ready, DBL); end
      checks++; if (out_valid !== 1'b0 || out_vector !== exp) begin
        failures++; $display("FAIL t2_hold cyc=%0d valid=%0b vec=%h exp_vec=%h", i, out_valid, out_vector, exp);
      end
      step();
    end
    fc_ready = 1'b1;
    step();
    fc_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_vector !== exp) begin
      failures++; $display("FAIL t2_release valid=%0b vec=%h exp_vec=%h", out_valid, out_vector, exp);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL t2_extra_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_short_frame();
    logic [399:0] prev, exp;
    prev = build_vec(16'hA000);
    exp  = build_vec(16'h3100);
    fc_ready = 1'b1;
    send_words(16'h3000, 11, 10);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL t3_err got=%0b exp=1", frame_err); end
    checks++; if (out_vector !== prev) begin failures++; $display("FAIL t3_vec_kept got=%h exp=%h", out_vector, prev); end
    step();
    checks++; if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL t3_after err=%0b valid=%0b exp 0 0", frame_err, out_valid);
    end
    send_words(16'h3100, 25, 24);
    checks++; if (out_vector !== exp) begin failures++; $display("FAIL t3_repack got=%h exp=%h", out_vector, exp); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t3_pulse got=%0b exp=1", out_valid); end
    step();
  endtask

  task automatic test_missing_last();
    logic [399:0] prev;
    prev = build_vec(16'h3100);
    send_words(16'h4000, 25, -1);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL t4_err got=%0b exp=1", frame_err); end
    checks++; if (out_vector !== prev) begin failures++; $display("FAIL t4_vec_kept got=%h exp=%h", out_vector, prev); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL t4_in_ready got=%0b exp=1", in_ready); end
    step();
    checks++; if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL t4_after err=%0b valid=%0b exp 0 0", frame_err, out_valid);
    end
  endtask

  task automatic test_midframe_reset();
    logic [399:0] exp;
    exp = build_vec(16'h5100);
    fc_ready = 1'b1;
    send_words(16'h5000, 12, -1);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_vector !== 400'd0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL t5_reset_outs vec=%h valid=%0b err=%0b exp all 0", out_vector, out_valid, frame_err);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL t5_reset_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    step();
    send_words(16'h5100, 25, 24);
    checks++; if (out_vector !== exp) begin failures++; $display("FAIL t5_fresh got=%h exp=%h", out_vector, exp); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t5_pulse got=%0b exp=1", out_valid); end
    step();
  endtask

`ifdef BNN_FLATTEN_PACK_DOUBLE_BUF_EN
  task automatic test_double_buf();
    logic [399:0] f1, f2;
    f1 = build_vec(16'h6000);
    f2 = build_vec(16'h7000);
    do_reset();
    fc_ready = 1'b0;
    send_words(16'h6000, 25, 24);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL t6_ready_after_f1 got=%0b exp=1", in_ready); end
    send_words(16'h7000, 25, 24);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL t6_ready_after_f2 got=%0b exp=0", in_ready); end
    step();
    fc_ready = 1'b1;
    step();
    fc_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_vector !== f1) begin
      failures++; $display("FAIL t6_first valid=%0b vec=%h exp_vec=%h", out_valid, out_vector, f1);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL t6_ready_freed got=%0b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_vector !== f2) begin
      failures++; $display("FAIL t6_reload valid=%0b vec=%h exp_vec=%h", out_valid, out_vector, f2);
    end
    fc_ready = 1'b1;
    step();
    fc_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_vector !== f2) begin
      failures++; $display("FAIL t6_second valid=%0b vec=%h exp_vec=%h", out_valid, out_vector, f2);
    end
    step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0000;
    in_last = 1'b0;
    fc_ready = 1'b0;
    #3;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_short_frame();
    test_missing_last();
    test_midframe_reset();
`ifdef BNN_FLATTEN_PACK_DOUBLE_BUF_EN
    test_double_buf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
